// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of quadratic integrate-and-fire neurons.
// One shared update engine walks the slots 0..N_NEURONS-1. Each neuron's
// membrane, bias and refractory state lives in its own cell instance.
// Spikes leave through a valid/ready handshake that stalls the engine
// while an event is pending and not yet accepted.

module qif_neuron_cell #(
  parameter int WIDTH   = 8,
  parameter int RW      = 2,
  parameter int V_RESET = -32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_upd,
  input  logic signed [WIDTH-1:0] i_v_nxt,
  input  logic [RW-1:0]           i_r_nxt,
  input  logic                    i_cfg_we,
  input  logic signed [WIDTH-1:0] i_cfg_bias,
  output logic signed [WIDTH-1:0] o_v,
  output logic signed [WIDTH-1:0] o_b,
  output logic [RW-1:0]           o_r
);
  localparam logic signed [WIDTH-1:0] VRST = WIDTH'(V_RESET);

  logic signed [WIDTH-1:0] r_v;
  logic signed [WIDTH-1:0] r_b;
  logic [RW-1:0]           r_r;

  // Membrane and refractory state change only when the engine is on this slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= VRST;
      r_r <= '0;
    end else if (i_upd) begin
      r_v <= i_v_nxt;
      r_r <= i_r_nxt;
    end
  end

  // Bias is written independently of the engine, including during stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_b <= '0;
    else if (i_cfg_we) r_b <= i_cfg_bias;
  end

  assign o_v = r_v;
  assign o_b = r_b;
  assign o_r = r_r;
endmodule

module qif_neuron_array #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 4,
  parameter int SQ_SHIFT  = 4,
  parameter int V_TH      = 96,
  parameter int V_RESET   = -32,
  parameter int REFRACT   = 3,
  parameter int AW        = (N_NEURONS > 2) ? $clog2(N_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic signed [WIDTH-1:0] cfg_bias,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic [AW-1:0]           spike_idx,
  output logic                    v_valid,
  output logic [AW-1:0]           v_idx,
  output logic signed [WIDTH-1:0] v_out
);
  // Sum is carried wide enough that V + (V*V >> k) + B can never wrap
  localparam int SW = 2*WIDTH + 2;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic signed [WIDTH-1:0] VRST  = WIDTH'(V_RESET);
  localparam logic signed [WIDTH-1:0] VTH   = WIDTH'(V_TH);
  localparam logic [RW-1:0]           RLOAD = RW'(REFRACT);
  localparam logic [AW-1:0]           LAST  = AW'(N_NEURONS - 1);

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic              spike;
    logic [RW-1:0]     r;
    logic [WIDTH-1:0]  v;
  } upd_t;

  logic [N_NEURONS-1:0][WIDTH-1:0] w_v_all;
  logic [N_NEURONS-1:0][WIDTH-1:0] w_b_all;
  logic [N_NEURONS-1:0][RW-1:0]    w_r_all;

  logic [AW-1:0]           r_idx;
  logic                    r_spike_valid;
  logic [AW-1:0]           r_spike_idx;
  logic                    r_v_valid;
  logic [AW-1:0]           r_v_idx;
  logic signed [WIDTH-1:0] r_v_out;

  logic                    w_exec;
  logic signed [WIDTH-1:0] w_v_cur;
  logic signed [WIDTH-1:0] w_b_cur;
  logic [RW-1:0]           w_r_cur;
  logic signed [SW-1:0]    w_v_ext;
  logic signed [SW-1:0]    w_b_ext;
  logic signed [SW-1:0]    w_sq;
  logic signed [SW-1:0]    w_sum;
  logic signed [WIDTH-1:0] w_sat;
  upd_t                    w_upd;

  // A pending, unaccepted spike freezes the engine
  assign w_exec = en & ~(r_spike_valid & ~spike_ready);

  assign w_v_cur = $signed(w_v_all[r_idx]);
  assign w_b_cur = $signed(w_b_all[r_idx]);
  assign w_r_cur = w_r_all[r_idx];

  assign w_v_ext = {{(SW-WIDTH){w_v_cur[WIDTH-1]}}, w_v_cur};
  assign w_b_ext = {{(SW-WIDTH){w_b_cur[WIDTH-1]}}, w_b_cur};
  assign w_sq    = (w_v_ext * w_v_ext) >>> SQ_SHIFT;
  assign w_sum   = w_v_ext + w_sq + w_b_ext;

  // Clamp the wide sum back into the membrane range
  always_comb begin
    w_sat = w_sum[WIDTH-1:0];
    if (w_sum > SAT_MAX)      w_sat = SAT_MAX[WIDTH-1:0];
    else if (w_sum < SAT_MIN) w_sat = SAT_MIN[WIDTH-1:0];
  end

  // Next state of the current slot: refractory hold, spike, or integrate
  always_comb begin
    w_upd.spike = 1'b0;
    w_upd.r     = '0;
    w_upd.v     = w_sat;
    if (w_r_cur != '0) begin
      w_upd.r = w_r_cur - 1'b1;
      w_upd.v = VRST;
    end else if (w_sat >= VTH) begin
      w_upd.spike = 1'b1;
      w_upd.r     = RLOAD;
      w_upd.v     = VRST;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_NEURONS; g++) begin : g_cell
      qif_neuron_cell #(
        .WIDTH   (WIDTH),
        .RW      (RW),
        .V_RESET (V_RESET)
      ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .i_upd      (w_exec && (r_idx == AW'(g))),
        .i_v_nxt    (w_upd.v),
        .i_r_nxt    (w_upd.r),
        .i_cfg_we   (cfg_we && (cfg_addr == AW'(g))),
        .i_cfg_bias (cfg_bias),
        .o_v        (w_v_all[g]),
        .o_b        (w_b_all[g]),
        .o_r        (w_r_all[g])
      );
    end
  endgenerate

  // Slot sequencer, wraps after the last neuron
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_idx <= '0;
    else if (w_exec) r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
  end

  // Spike event register: a new spike wins over clearing on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
    end else if (w_exec && w_upd.spike) begin
      r_spike_valid <= 1'b1;
      r_spike_idx   <= r_idx;
    end else if (r_spike_valid && spike_ready) begin
      r_spike_valid <= 1'b0;
    end
  end

  // Membrane monitor, one cycle behind the executing slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_valid <= 1'b0;
      r_v_idx   <= '0;
      r_v_out   <= VRST;
    end else begin
      r_v_valid <= w_exec;
      if (w_exec) begin
        r_v_idx <= r_idx;
        r_v_out <= w_upd.v;
      end
    end
  end

  assign spike_valid = r_spike_valid;
  assign spike_idx   = r_spike_idx;
  assign v_valid     = r_v_valid;
  assign v_idx       = r_v_idx;
  assign v_out       = r_v_out;
endmodule
